// File: rtl/nn_pkg.sv
// Shared neural-layer types: operand widths, int8/int16 aliases and the MAC
// control states.
package nn_pkg;
  localparam int ACT_W  = 8;
  localparam int PROD_W = 16;

  typedef logic signed [ACT_W-1:0]  act_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/nn_sat_add.sv
// Combinational signed saturating adder. The result clamps to the W-bit signed
// range, and ovf flags any clamp.
module nn_sat_add #(
  parameter int W = 20
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);
  logic signed [W-1:0] raw;

  always_comb begin
    raw   = a_i + b_i;
    // Overflow only possible when operands share a sign and the result flips it.
    ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
    if (ovf_o) sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else       sum_o = raw;
  end
endmodule

// File: rtl/neuron_mac_accum.sv
// Serial int8 MAC neuron. It accumulates one x*w product per beat plus the bias
// taken on the first beat, then holds the saturated wide sum until the consumer
// accepts it.
module neuron_mac_accum
  import nn_pkg::*;
#(
  parameter int  ACC_WIDTH = 20,
  parameter int  MAX_LEN   = 64,
  localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_W-1:0]     in_x,
  input  logic [ACT_W-1:0]     in_w,
  input  logic [ACT_W-1:0]     in_bias,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_sat,
  output logic [CNT_W-1:0]     out_len
);
  state_e                state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sat_q, sat_d;
  logic [ACC_WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic                  osat_q, osat_d;

  prod_t                 prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, add_sum;
  logic                  add_ovf, beat;

  // Widen before multiplying so the full 16-bit product is kept.
  assign prod     = prod_t'(act_t'(in_x)) * prod_t'(act_t'(in_w));
  assign prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH-ACT_W){in_bias[ACT_W-1]}}, in_bias};

  nn_sat_add #(.W(ACC_WIDTH)) u_sat_add (
    .a_i  (acc_q),
    .b_i  (prod_ext),
    .sum_o(add_sum),
    .ovf_o(add_ovf)
  );

  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = ~out_valid;
  assign beat      = in_valid & in_ready;
  assign out_sum   = sum_q;
  assign out_sat   = osat_q;
  assign out_len   = len_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    len_d   = len_q;
    osat_d  = osat_q;
    case (state_q)
      ST_FIRST, ST_ACCUM: begin
        if (beat) begin
          if (state_q == ST_FIRST) begin
            // Bias plus one product always fits in ACC_WIDTH >= 17 bits.
            acc_d = bias_ext + prod_ext;
            sat_d = 1'b0;
            cnt_d = CNT_W'(1);
          end else begin
            acc_d = add_sum;
            sat_d = sat_q | add_ovf;
            cnt_d = cnt_q + CNT_W'(1);
          end
          // The beat that reaches MAX_LEN closes the vector even without in_last.
          if (in_last || cnt_d == CNT_W'(MAX_LEN)) begin
            state_d = ST_HOLD;
            sum_d   = acc_d;
            len_d   = cnt_d;
            osat_d  = sat_d;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_HOLD: if (out_ready) state_d = ST_FIRST;
      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FIRST;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      len_q   <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      osat_q  <= osat_d;
    end
  end
endmodule

// File: tb/tb_neuron_mac_accum.sv
// Randomised and directed bench for neuron_mac_accum. A vector-level integer
// model tracks the expected handshake and result registers every cycle.
module tb_neuron_mac_accum;
  localparam int AW   = 17;
  localparam int ML   = 8;
  localparam int CW   = $clog2(ML + 1);
  localparam int SMAX = (1 <<< (AW - 1)) - 1;
  localparam int SMIN = -(1 <<< (AW - 1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_x = '0, in_w = '0, in_bias = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic          out_sat;
  logic [CW-1:0] out_len;

  neuron_mac_accum #(.ACC_WIDTH(AW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_sat(out_sat), .out_len(out_len)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Model: beats taken so far, running value, and the last published result.
  bit m_hold = 0, m_sat = 0, e_sat = 0;
  int m_n = 0, m_acc = 0, e_sum = 0, e_len = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int xi, wi, bi, p, s;
    xi = $signed(in_x);
    wi = $signed(in_w);
    bi = $signed(in_bias);
    if (!rst_n) begin
      m_hold = 0; m_n = 0; m_acc = 0; m_sat = 0;
      e_sum = 0; e_len = 0; e_sat = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      p = xi * wi;
      if (m_n == 0) begin
        m_acc = bi + p;
        m_sat = 0;
      end else begin
        s = m_acc + p;
        if (s > SMAX) begin s = SMAX; m_sat = 1; end
        else if (s < SMIN) begin s = SMIN; m_sat = 1; end
        m_acc = s;
      end
      m_n++;
      if (in_last || m_n == ML) begin
        m_hold = 1; e_sum = m_acc; e_len = m_n; e_sat = m_sat; m_n = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", out_valid, m_hold);
    chk("in_ready", in_ready, !m_hold);
    chk("out_sum", longint'($signed(out_sum)), e_sum);
    chk("out_len", out_len, e_len);
    chk("out_sat", out_sat, e_sat);
  endtask

  task automatic drv(input bit v, input int x, input int w, input int b,
                     input bit l, input bit r);
    in_valid = v; in_x = x[7:0]; in_w = w[7:0]; in_bias = b[7:0];
    in_last = l; out_ready = r;
    step();
  endtask

  task automatic idle(input bit r);
    drv(1'b0, 0, 0, 0, 1'b0, r);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle(0); idle(0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_sum", out_sum, 0);
    rst_n = 1'b1;
    idle(0);

    // Basic dot product
    drv(1, 2, 3, 5, 0, 0);
    drv(1, -4, 7, 99, 0, 0);
    drv(1, 10, 10, 99, 1, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_sum", longint'($signed(out_sum)), 83);
    chk("t2_len", out_len, 3);
    chk("t2_sat", out_sat, 0);
    idle(1);
    chk("t2_drop", out_valid, 0);

    // Backpressure: an offered beat must stall while the result is held
    drv(1, 3, 3, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 7, 7, 7, 1, 0);
      chk("t3_ready", in_ready, 0);
      chk("t3_sum", longint'($signed(out_sum)), 10);
    end
    idle(1);
    chk("t3_rel_valid", out_valid, 0);
    chk("t3_rel_ready", in_ready, 1);

    // Reset mid-vector discards the partial sum
    drv(1, 50, 50, 20, 0, 0);
    drv(1, 50, 50, 20, 0, 0);
    drv(1, 50, 50, 20, 0, 0);
    rst_n = 1'b0;
    idle(0);
    rst_n = 1'b1;
    chk("t1_valid", out_valid, 0);
    chk("t1_ready", in_ready, 1);
    drv(1, 1, 1, 7, 1, 0);
    chk("t1_sum", longint'($signed(out_sum)), 8);
    chk("t1_len", out_len, 1);
    idle(1);

    // Saturation high then recovery; the sticky flag stays set
    for (int i = 0; i < 5; i++) drv(1, -128, -128, 0, 0, 0);
    drv(1, -128, 127, 0, 1, 0);
    chk("t4_sum", longint'($signed(out_sum)), 49279);
    chk("t4_sat", out_sat, 1);
    idle(1);

    // Length cap: no in_last; extra beats stall, then form the next vector
    for (int i = 0; i < 10; i++) drv(1, 1, 1, 3, 0, 0);
    chk("t5_len", out_len, ML);
    chk("t5_sum", longint'($signed(out_sum)), ML + 3);
    idle(1);
    drv(1, 1, 1, 3, 0, 0);
    drv(1, 1, 1, 3, 1, 0);
    chk("t5_next", longint'($signed(out_sum)), 5);
    idle(1);

    // Bubbles between beats, then a single-beat vector
    drv(1, 9, -5, -2, 0, 0); idle(0);
    drv(1, 4, 4, 0, 0, 0);   idle(0); idle(0);
    drv(1, -3, 6, 0, 1, 0);
    chk("t6_bub", longint'($signed(out_sum)), -45 - 2 + 16 - 18);
    idle(1);
    drv(1, -128, -128, -128, 1, 0);
    chk("t6_single", longint'($signed(out_sum)), 16256);
    chk("t6_len", out_len, 1);
    idle(1);

    // Random traffic, biased toward extreme operands to hit both clamps
    for (int c = 0; c < 3000; c++) begin
      int x, w;
      x = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 127 : -128)
                                       : int'($urandom_range(0, 255)) - 128;
      w = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 127 : -128)
                                       : int'($urandom_range(0, 255)) - 128;
      rst_n = ($urandom_range(0, 199) != 0);
      drv($urandom_range(0, 3) != 0, x, w, int'($urandom_range(0, 255)),
          $urandom_range(0, 6) == 0, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
